// File: rtl/bounds_fifo_sched.sv
// Bounds FIFO scheduler: occupancy tracking, gated writes, credit-based reads into a
// 2-entry skid buffer, and end-of-block flush sequencing. Define BOUNDS_CHECK_EN to add err_bounds.
module bounds_fifo_sched #(
  parameter int DEPTH = 512,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   up_upper_bound,
  input  logic [15:0]   up_lower_bound,
  input  logic          up_valid,
  output logic          up_ready,
  output logic [31:0]   fifo_din,
  output logic          fifo_wr_en,
  output logic          fifo_rd_en,
  input  logic [31:0]   fifo_dout,
  input  logic          fifo_valid,
  output logic [15:0]   dn_upper_bound,
  output logic [15:0]   dn_lower_bound,
  output logic          dn_valid,
  input  logic          dn_ready,
  input  logic          flush_req,
  output logic          flush_done,
  output logic [CW-1:0] occupancy
`ifdef BOUNDS_CHECK_EN
  ,
  output logic          err_bounds
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        inflight;
  logic [1:0]  skid_count;
  logic [31:0] skid_head, skid_tail;
  logic [1:0]  credit_used;
  logic        push, pop, drained;

  assign up_ready   = !rst && (state == RUN) && (occupancy < CW'(DEPTH));
  assign fifo_wr_en = up_valid && up_ready;
  assign fifo_din   = {up_upper_bound, up_lower_bound};

  assign push        = fifo_valid;
  assign dn_valid    = (skid_count != 2'd0);
  assign pop         = dn_valid && dn_ready;
  assign credit_used = skid_count + {1'b0, inflight};

  // A pop in the same cycle frees one credit, which sustains one read per cycle.
  assign fifo_rd_en = (occupancy != '0) && ((credit_used < 2'd2) || pop);

  assign dn_upper_bound = skid_head[31:16];
  assign dn_lower_bound = skid_head[15:0];
  assign flush_done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (fifo_wr_en && !fifo_rd_en) begin
      occupancy <= occupancy + CW'(1);
    end else if (!fifo_wr_en && fifo_rd_en) begin
      occupancy <= occupancy - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else if (fifo_rd_en) begin
      inflight <= 1'b1;
    end else if (fifo_valid) begin
      inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_count <= '0;
      skid_head  <= '0;
      skid_tail  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (skid_count == 2'd0) skid_head <= fifo_dout;
          else                    skid_tail <= fifo_dout;
          skid_count <= skid_count + 2'd1;
        end
        2'b01: begin
          skid_head  <= skid_tail;
          skid_count <= skid_count - 2'd1;
        end
        2'b11: begin
          if (skid_count == 2'd1) begin
            skid_head <= fifo_dout;
          end else begin
            skid_head <= skid_tail;
            skid_tail <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // Drain completes on the cycle of the final pop so flush_done follows it directly.
  assign drained = (occupancy == '0) && !inflight &&
                   ((skid_count == 2'd0) || ((skid_count == 2'd1) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (flush_req) state_next = DRAIN;
      DRAIN:   if (drained)   state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

`ifdef BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bounds <= 1'b0;
    end else if (fifo_wr_en && (up_upper_bound <= up_lower_bound)) begin
      err_bounds <= 1'b1;
    end
  end
`endif

endmodule
